// File: rtl/argmax_accumulator.sv
// rtl/argmax_accumulator.sv - folds per-chunk (max, argmax) results into a global argmax; optional macro ARGMAX_ACCUMULATOR_EARLY_LAST_EN adds in_last
module argmax_accumulator #(
    parameter int WIDTH      = 8,
    parameter int N          = 8,
    parameter int NUM_CHUNKS = 16,
    localparam int LANE_W    = (N > 1) ? $clog2(N) : 1,
    localparam int IDX_W     = (N * NUM_CHUNKS > 1) ? $clog2(N * NUM_CHUNKS) : 1,
    localparam int CNT_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_max,
    input  logic [LANE_W-1:0]       in_argmax,
`ifdef ARGMAX_ACCUMULATOR_EARLY_LAST_EN
    input  logic                    in_last,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_max,
    output logic [IDX_W-1:0]        out_argmax
);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        chunk_cnt;
    logic signed [WIDTH-1:0] run_max;
    logic [IDX_W-1:0]        run_idx;

    logic [IDX_W-1:0]        cand_idx;
    logic                    take;
    logic                    is_last;
    logic signed [WIDTH-1:0] win_max;
    logic [IDX_W-1:0]        win_idx;

    // Candidate from the incoming chunk; strict compare keeps the earlier (lower) index on ties.
    always_comb begin
        cand_idx = IDX_W'(chunk_cnt) * IDX_W'(N) + IDX_W'(in_argmax);
        take     = (chunk_cnt == CNT_W'(0)) || (in_max > run_max);
        win_max  = take ? in_max : run_max;
        win_idx  = take ? cand_idx : run_idx;
`ifdef ARGMAX_ACCUMULATOR_EARLY_LAST_EN
        is_last  = (chunk_cnt == CNT_W'(NUM_CHUNKS - 1)) || in_last;
`else
        is_last  = (chunk_cnt == CNT_W'(NUM_CHUNKS - 1));
`endif
    end

    // Accumulate chunks in ACCUM, hold the registered result in DONE until it is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ACCUM;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            chunk_cnt  <= '0;
            run_max    <= '0;
            run_idx    <= '0;
            out_max    <= '0;
            out_argmax <= '0;
        end else if (state == ACCUM) begin
            if (in_valid) begin
                run_max <= win_max;
                run_idx <= win_idx;
                if (is_last) begin
                    out_max    <= win_max;
                    out_argmax <= win_idx;
                    chunk_cnt  <= '0;
                    state      <= DONE;
                    in_ready   <= 1'b0;
                    out_valid  <= 1'b1;
                end else begin
                    chunk_cnt <= chunk_cnt + CNT_W'(1);
                end
            end
        end else begin
            if (out_ready) begin
                state     <= ACCUM;
                in_ready  <= 1'b1;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_argmax_accumulator.sv
// tb/tb_argmax_accumulator.sv - scoreboard bench for argmax_accumulator (N=8, NUM_CHUNKS=4)
module tb_argmax_accumulator;

    localparam int WIDTH      = 8;
    localparam int N          = 8;
    localparam int NUM_CHUNKS = 4;
    localparam int LANE_W     = 3;
    localparam int IDX_W      = 5;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_max;
    logic [LANE_W-1:0]       in_argmax;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_max;
    logic [IDX_W-1:0]        out_argmax;

    typedef struct {
        logic signed [WIDTH-1:0] m;
        logic [IDX_W-1:0]        i;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    argmax_accumulator #(.WIDTH(WIDTH), .N(N), .NUM_CHUNKS(NUM_CHUNKS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_max     (in_max),
        .in_argmax  (in_argmax),
`ifdef ARGMAX_ACCUMULATOR_EARLY_LAST_EN
        .in_last    (in_last),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_argmax (out_argmax)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every result transfer is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got max=%0d idx=%0d expected no result", out_max, out_argmax);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_max", int'(out_max), int'(e.m));
                check("out_argmax", int'(out_argmax), int'(e.i));
            end
        end
    end

    task automatic send(input int m, input int a, input logic last);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_max    = WIDTH'(m);
        in_argmax = LANE_W'(a);
        in_last   = last;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push(input int m, input int i);
        exp_t e;
        e.m = WIDTH'(m);
        e.i = IDX_W'(i);
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_max    = '0;
        in_argmax = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_max", int'(out_max), 0);
        check("reset_out_argmax", int'(out_argmax), 0);

        // Basic sequence: winner in chunk 1 lane 5 -> 13
        push(10, 13);
        send(3, 1, 1'b0); send(10, 5, 1'b0); send(-2, 0, 1'b0);
        send(7, 7, 1'b0);
        @(negedge clk);
        check("latency_out_valid", int'(out_valid), 1);
        drain();

        // Ties keep the first index
        push(5, 2);
        send(5, 2, 1'b0); send(5, 0, 1'b0); send(5, 6, 1'b0); send(5, 3, 1'b0);
        drain();

        // All negative values, tie on -100 keeps index 9
        push(-100, 9);
        send(-128, 4, 1'b0); send(-100, 1, 1'b0); send(-100, 2, 1'b0); send(-127, 0, 1'b0);
        drain();

        // Back-pressure: result held while in_valid is asserted in DONE
        out_ready = 1'b0;
        send(1, 0, 1'b0); send(2, 1, 1'b0); send(3, 2, 1'b0); send(4, 3, 1'b0);
        in_valid  = 1'b1;
        in_max    = 8'sd99;
        in_argmax = 3'd7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_max", int'(out_max), 4);
            check("bp_out_argmax", int'(out_argmax), 27);
        end
        push(4, 27);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", int'(in_ready), 1);
        check("bp_release_out_valid", int'(out_valid), 0);
        drain();
        push(-50, 0);
        send(-50, 0, 1'b0); send(-60, 1, 1'b0); send(-70, 2, 1'b0); send(-80, 3, 1'b0);
        drain();

        // Mid-run reset discards the partial accumulation
        send(100, 0, 1'b0); send(100, 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_out_valid", int'(out_valid), 0);
        push(7, 19);
        send(5, 1, 1'b0); send(6, 2, 1'b0); send(7, 3, 1'b0); send(2, 4, 1'b0);
        drain();

`ifdef ARGMAX_ACCUMULATOR_EARLY_LAST_EN
        // Early termination, then a full sequence counting from chunk 0 again
        push(9, 11);
        send(1, 0, 1'b0); send(9, 3, 1'b1);
        drain();
        push(8, 22);
        send(2, 0, 1'b0); send(2, 1, 1'b0); send(8, 6, 1'b0); send(3, 0, 1'b0);
        drain();
`endif

        repeat (3) @(negedge clk);
        check("final_out_valid", int'(out_valid), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/argmax_accumulator.md
ARGMAX_ACCUMULATOR -- requirements
Module: argmax_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: signed width of every compared value.
REQ-002 Parameter N, default 8: lanes per chunk; the index in each chunk is $clog2(N) bits wide.
REQ-003 Parameter NUM_CHUNKS, default 16: number of chunks in one classification; IDX_W = $clog2(N*NUM_CHUNKS).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  chunk result present.
REQ-007 in_ready  output  1  block accepts a chunk this cycle.
REQ-008 in_max  input  WIDTH signed  maximum value of the chunk, from the upstream argmax tree.
REQ-009 in_argmax  input  $clog2(N)  lane of that maximum within the chunk.
REQ-010 out_valid  output  1  final result held.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_max  output  WIDTH signed  global maximum over all chunks.
REQ-013 out_argmax  output  IDX_W  global index of the maximum.

Function
REQ-014 A chunk transfer SHALL occur on a cycle where in_valid and in_ready are both high; a result transfer SHALL occur on a cycle where out_valid and out_ready are both high.
REQ-015 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-016 In ACCUM, the block SHALL keep chunk_cnt (0..NUM_CHUNKS-1), run_max (WIDTH signed) and run_idx (IDX_W).
REQ-017 For each accepted chunk, the global candidate index SHALL be chunk_cnt*N + in_argmax, computed at IDX_W bits with no truncation.
REQ-018 The first chunk accepted (chunk_cnt=0) SHALL load run_max and run_idx unconditionally.
REQ-019 A later chunk SHALL replace run_max and run_idx only when in_max > run_max (signed, strict compare).
REQ-020 On a tie, the lower index SHALL win, matching the tie rule of the upstream tree.
REQ-021 On the transfer where chunk_cnt = NUM_CHUNKS-1, the block SHALL include that chunk in the compare.
REQ-022 On that same transfer, the block SHALL register the winning max and index into out_max and out_argmax.
REQ-023 On that same transfer, the block SHALL reset chunk_cnt to 0 and enter DONE.
REQ-024 out_valid SHALL rise one cycle after the last chunk transfer; latency from last chunk to result = 1 cycle.
REQ-025 In DONE, out_max and out_argmax SHALL stay stable until the result transfer.
REQ-026 On the result transfer, the block SHALL return to ACCUM on the next edge.
REQ-027 In DONE, in_valid SHALL be ignored even when out_ready is high in the same cycle; no chunk is accepted in DONE.
REQ-028 In ACCUM, chunk_cnt SHALL advance by exactly one per transfer, and idle cycles SHALL change no state.
REQ-029 If NUM_CHUNKS=1, every transfer SHALL be the last one.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL enter ACCUM with chunk_cnt=0, run_max=0, run_idx=0, out_max=0, out_argmax=0 and out_valid=0.
REQ-031 After reset, in_ready SHALL be 1 from the first cycle with rst_n=1.
REQ-032 A reset during a partial accumulation or while in DONE SHALL discard all accumulated data, and the pending result SHALL never be presented.

Configuration
REQ-033 The macro ARGMAX_ACCUMULATOR_EARLY_LAST_EN SHALL control early termination.
REQ-034 With ARGMAX_ACCUMULATOR_EARLY_LAST_EN defined, the block SHALL add input port in_last (1 bit).
REQ-035 With the macro defined, a transfer with in_last=1 SHALL act as the last chunk (REQ-021 to REQ-023) whatever chunk_cnt is.
REQ-036 With the macro defined, reaching chunk_cnt=NUM_CHUNKS-1 SHALL still terminate the accumulation.
REQ-037 Without the macro, the in_last port SHALL not exist, and termination SHALL be by count only.

Verification
REQ-038 Reset, then NUM_CHUNKS=4, N=8, chunks (max, argmax) = (3,1), (10,5), (-2,0), (7,7) -> one cycle after the 4th chunk: out_valid=1, out_max=10, out_argmax=13.
REQ-039 Ties: chunks (5,2), (5,0), (5,6), (5,3) -> out_max=5, out_argmax=2.
REQ-040 All-negative: chunks (-128,4), (-100,1), (-100,2), (-127,0) -> out_max=-100, out_argmax=9.
REQ-041 Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable for those 5 cycles; raise out_ready -> next cycle in_ready=1, and the next sequence starts fresh (the first chunk (-50,0) gives out_max=-50 at the end when it stays highest).
REQ-042 Mid-run reset: accept 2 chunks, pulse rst_n=0 for one edge, then send 4 new chunks -> the result reflects only the 4 new chunks.
REQ-043 With ARGMAX_ACCUMULATOR_EARLY_LAST_EN: chunks (1,0) then (9,3) with in_last=1 -> out_max=9, out_argmax=11; chunk_cnt restarts at 0.
